// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with pending scoreboard; define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding
module regfile_mp_sb #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32,
   parameter int NRD    = 4,
   parameter int NWR    = 2,
   parameter int NAL    = 2,
   localparam int AW    = $clog2(NREG)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [AW-1:0]     ra_i     [NRD],
   output logic [DATA_W-1:0] rdata_o  [NRD],
   output logic              rready_o [NRD],
   input  logic              wvalid_i [NWR],
   input  logic [AW-1:0]     wid_i    [NWR],
   input  logic [DATA_W-1:0] wdata_i  [NWR],
   input  logic              avalid_i [NAL],
   input  logic [AW-1:0]     aid_i    [NAL],
   input  logic              flush_i
);
   logic [DATA_W-1:0] regs_q [NREG-1:1];
   logic [DATA_W-1:0] regs_d [NREG-1:1];
   logic [NREG-1:1]   pend_q, pend_d;
   // next state: writes in port order so the highest port wins; alloc applied after writeback clear, flush last
   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      for (int j = 0; j < NWR; j++)
         if (wvalid_i[j] && wid_i[j] != '0) begin
            regs_d[wid_i[j]] = wdata_i[j];
            pend_d[wid_i[j]] = 1'b0;
         end
      for (int k = 0; k < NAL; k++)
         if (avalid_i[k] && aid_i[k] != '0) pend_d[aid_i[k]] = 1'b1;
      if (flush_i) pend_d = '0;
   end
   // state registers, reset clears data and pending bits
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 1; i < NREG; i++) regs_q[i] <= '0;
         pend_q <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
      end
   end
   // read ports: r0 reads zero and ready; reset forces the idle view
   always_comb begin
      for (int i = 0; i < NRD; i++) begin
         rdata_o[i]  = '0;
         rready_o[i] = 1'b1;
         if (ra_i[i] != '0) begin
            rdata_o[i]  = regs_q[ra_i[i]];
            rready_o[i] = ~pend_q[ra_i[i]];
         end
`ifdef REGFILE_BYPASS_EN
         for (int j = 0; j < NWR; j++)
            if (ra_i[i] != '0 && wvalid_i[j] && wid_i[j] == ra_i[i]) begin
               rdata_o[i]  = wdata_i[j];
               rready_o[i] = 1'b1;
            end
         for (int k = 0; k < NAL; k++)
            for (int j = 0; j < NWR; j++)
               if (ra_i[i] != '0 && wvalid_i[j] && wid_i[j] == ra_i[i] && avalid_i[k] && aid_i[k] == ra_i[i])
                  rready_o[i] = 1'b0;
`endif
         if (reset_i) begin
            rdata_o[i]  = '0;
            rready_o[i] = 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed self-checking bench for regfile_mp_sb
module tb_regfile_mp_sb;
   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  ra     [4];
   logic [31:0] rdata  [4];
   logic        rready [4];
   logic        wvalid [2];
   logic [4:0]  wid    [2];
   logic [31:0] wdata  [2];
   logic        avalid [2];
   logic [4:0]  aid    [2];
   logic        flush;
   int          checks = 0;
   int          fails  = 0;

   regfile_mp_sb dut (
      .clk_i(clk), .reset_i(reset), .ra_i(ra), .rdata_o(rdata), .rready_o(rready),
      .wvalid_i(wvalid), .wid_i(wid), .wdata_i(wdata),
      .avalid_i(avalid), .aid_i(aid), .flush_i(flush)
   );

   always #5 clk = ~clk;

   task automatic idle();
      for (int j = 0; j < 2; j++) begin
         wvalid[j] = 1'b0; wid[j] = '0; wdata[j] = '0;
         avalid[j] = 1'b0; aid[j] = '0;
      end
      flush = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      for (int p = 0; p < 4; p++) ra[p] = '0;
      step(); step();
      reset = 1'b0;
      for (int id = 0; id < 32; id++) begin
         for (int p = 0; p < 4; p++) ra[p] = 5'((id + p) % 32);
         #1;
         for (int p = 0; p < 4; p++) begin
            checks++;
            if (rdata[p] !== 32'h0 || rready[p] !== 1'b1) begin
               fails++;
               $display("FAIL reset_read port%0d id%0d: got data=%h ready=%b, want 0/1", p, ra[p], rdata[p], rready[p]);
            end
         end
      end
   endtask

   task automatic test_write();
      logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
      exp_same = 32'hDEADBEEF;
`else
      exp_same = 32'h0;
`endif
      wvalid[0] = 1'b1; wid[0] = 5'd5; wdata[0] = 32'hDEADBEEF; ra[0] = 5'd5;
      #1;
      checks++;
      if (rdata[0] !== exp_same) begin
         fails++;
         $display("FAIL write_same_cycle: got %h, want %h", rdata[0], exp_same);
      end
      step(); idle(); #1;
      checks++;
      if (rdata[0] !== 32'hDEADBEEF || rready[0] !== 1'b1) begin
         fails++;
         $display("FAIL write_next_cycle: got %h/%b, want deadbeef/1", rdata[0], rready[0]);
      end
   endtask

   task automatic test_priority();
      wvalid[0] = 1'b1; wid[0] = 5'd7; wdata[0] = 32'h11;
      wvalid[1] = 1'b1; wid[1] = 5'd7; wdata[1] = 32'h22;
      step(); idle(); ra[1] = 5'd7; #1;
      checks++;
      if (rdata[1] !== 32'h22) begin
         fails++;
         $display("FAIL write_priority: got %h, want 00000022", rdata[1]);
      end
   endtask

   task automatic test_scoreboard();
      avalid[0] = 1'b1; aid[0] = 5'd9;
      step(); idle(); ra[2] = 5'd9; #1;
      checks++;
      if (rready[2] !== 1'b0) begin
         fails++;
         $display("FAIL alloc_pending: got ready=%b, want 0", rready[2]);
      end
      wvalid[1] = 1'b1; wid[1] = 5'd9; wdata[1] = 32'h5;
      step(); idle(); #1;
      checks++;
      if (rready[2] !== 1'b1 || rdata[2] !== 32'h5) begin
         fails++;
         $display("FAIL writeback_clear: got %h/%b, want 00000005/1", rdata[2], rready[2]);
      end
      avalid[1] = 1'b1; aid[1] = 5'd9;
      wvalid[0] = 1'b1; wid[0] = 5'd9; wdata[0] = 32'h77;
      step(); idle(); #1;
      checks++;
      if (rready[2] !== 1'b0 || rdata[2] !== 32'h77) begin
         fails++;
         $display("FAIL alloc_beats_writeback: got %h/%b, want 00000077/0", rdata[2], rready[2]);
      end
   endtask

   task automatic test_r0();
      wvalid[0] = 1'b1; wid[0] = 5'd0; wdata[0] = 32'hFFFFFFFF;
      avalid[0] = 1'b1; aid[0] = 5'd0; ra[3] = 5'd0;
      #1;
      checks++;
      if (rdata[3] !== 32'h0 || rready[3] !== 1'b1) begin
         fails++;
         $display("FAIL r0_same_cycle: got %h/%b, want 0/1", rdata[3], rready[3]);
      end
      step(); idle(); #1;
      checks++;
      if (rdata[3] !== 32'h0 || rready[3] !== 1'b1) begin
         fails++;
         $display("FAIL r0_after: got %h/%b, want 0/1", rdata[3], rready[3]);
      end
   endtask

   task automatic test_flush_reset();
      avalid[0] = 1'b1; aid[0] = 5'd3;
      avalid[1] = 1'b1; aid[1] = 5'd4;
      step(); idle(); ra[0] = 5'd3; ra[1] = 5'd4; #1;
      checks++;
      if (rready[0] !== 1'b0 || rready[1] !== 1'b0) begin
         fails++;
         $display("FAIL alloc_two: got r3=%b r4=%b, want 0 0", rready[0], rready[1]);
      end
      flush = 1'b1; avalid[0] = 1'b1; aid[0] = 5'd6;
      step(); idle(); ra[2] = 5'd6; ra[3] = 5'd9; #1;
      checks++;
      if (rready[0] !== 1'b1 || rready[1] !== 1'b1 || rready[2] !== 1'b1 || rready[3] !== 1'b1) begin
         fails++;
         $display("FAIL flush: got r3=%b r4=%b r6=%b r9=%b, want all 1", rready[0], rready[1], rready[2], rready[3]);
      end
      checks++;
      if (rdata[3] !== 32'h77) begin
         fails++;
         $display("FAIL flush_keeps_data: got %h, want 00000077", rdata[3]);
      end
      avalid[0] = 1'b1; aid[0] = 5'd3;
      wvalid[0] = 1'b1; wid[0] = 5'd10; wdata[0] = 32'hAB;
      step(); idle(); ra[1] = 5'd10; #1;
      checks++;
      if (rready[0] !== 1'b0 || rdata[1] !== 32'hAB) begin
         fails++;
         $display("FAIL pre_reset: got r3=%b r10=%h, want 0 000000ab", rready[0], rdata[1]);
      end
      reset = 1'b1;
      wvalid[1] = 1'b1; wid[1] = 5'd11; wdata[1] = 32'h99;
      avalid[1] = 1'b1; aid[1] = 5'd12;
      ra[2] = 5'd11; ra[3] = 5'd12;
      #1;
      checks++;
      if (rdata[1] !== 32'h0 || rready[0] !== 1'b1 || rdata[2] !== 32'h0) begin
         fails++;
         $display("FAIL during_reset: got r10=%h r3=%b r11=%h, want 0 1 0", rdata[1], rready[0], rdata[2]);
      end
      step(); reset = 1'b0; idle(); #1;
      checks++;
      if (rready[0] !== 1'b1 || rdata[1] !== 32'h0 || rdata[2] !== 32'h0 || rready[3] !== 1'b1) begin
         fails++;
         $display("FAIL after_reset: got r3=%b r10=%h r11=%h r12=%b, want 1 0 0 1", rready[0], rdata[1], rdata[2], rready[3]);
      end
      ra[0] = 5'd5; ra[1] = 5'd7; ra[2] = 5'd9; #1;
      checks++;
      if (rdata[0] !== 32'h0 || rdata[1] !== 32'h0 || rdata[2] !== 32'h0) begin
         fails++;
         $display("FAIL after_reset_data: got r5=%h r7=%h r9=%h, want 0", rdata[0], rdata[1], rdata[2]);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_priority();
      test_scoreboard();
      test_r0();
      test_flush_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
